calc_acc_bank: RTL and testbench



---
 rtl/calc_pkg.sv | 26 ++
 rtl/calc_acc_bank_if.sv | 18 +
 rtl/calc_mul_seq.sv | 41 ++++
 rtl/calc_acc_bank.sv | 124 ++++++++++++
 tb/tb_calc_acc_bank.sv | 205 ++++++++++++++++++++
 5 files changed

// File: rtl/calc_pkg.sv
// calc_pkg: opcodes, flag bit positions and FSM states shared by the accumulator bank
package calc_pkg;
  typedef enum logic [3:0] {
    OP_ADD  = 4'h0,
    OP_SUB  = 4'h1,
    OP_OR   = 4'h2,
    OP_AND  = 4'h3,
    OP_XOR  = 4'h4,
    OP_SHL  = 4'h5,
    OP_SHR  = 4'h6,
    OP_SRA  = 4'h7,
    OP_NEG  = 4'h8,
    OP_NOT  = 4'h9,
    OP_REV  = 4'hA,
    OP_MUL  = 4'hB,
    OP_LOAD = 4'hC,
    OP_LTU  = 4'hD,
    OP_GTU  = 4'hE,
    OP_EQ   = 4'hF
  } op_e;
  localparam int FLG_C = 3;
  localparam int FLG_V = 2;
  localparam int FLG_N = 1;
  localparam int FLG_Z = 0;
  typedef enum logic {IDLE, MUL} state_e;
endpackage

// File: rtl/calc_acc_bank_if.sv
// calc_acc_bank_if: command handshake, read port and status of the accumulator bank
interface calc_acc_bank_if #(parameter int WIDTH = 8, parameter int NUM_ACC = 4);
  localparam int SELW = $clog2(NUM_ACC);
  logic             op_valid;
  logic             op_ready;
  logic [3:0]       op_code;
  logic [SELW-1:0]  op_sel;
  logic [WIDTH-1:0] op_data;
  logic [SELW-1:0]  rd_sel;
  logic [WIDTH-1:0] acc_out;
  logic [3:0]       flags;
  logic             busy;
  logic             done;
  modport master (output op_valid, op_code, op_sel, op_data, rd_sel,
                  input op_ready, acc_out, flags, busy, done);
  modport slave (input op_valid, op_code, op_sel, op_data, rd_sel,
                 output op_ready, acc_out, flags, busy, done);
endinterface

// File: rtl/calc_mul_seq.sv
// calc_mul_seq: WIDTH-cycle shift-add unsigned multiplier; product is the value after the current step
module calc_mul_seq #(parameter int WIDTH = 8) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               busy,
  output logic               last,
  output logic [2*WIDTH-1:0] product
);
  localparam int CW = $clog2(WIDTH);
  logic [2*WIDTH-1:0] part;
  logic [2*WIDTH-1:0] mc;
  logic [WIDTH-1:0]   mp;
  logic [CW-1:0]      cnt;
  assign last = busy && cnt == CW'(WIDTH - 1);
  assign product = part + (mp[0] ? mc : '0);
  // one shift-add step per busy cycle; a start reloads operands and clears the partial product
  always_ff @(posedge clk) begin
    if (rst) begin
      busy <= 1'b0;
      cnt  <= '0;
      part <= '0;
      mc   <= '0;
      mp   <= '0;
    end else if (start) begin
      busy <= 1'b1;
      cnt  <= '0;
      part <= '0;
      mc   <= {{WIDTH{1'b0}}, a};
      mp   <= b;
    end else if (busy) begin
      busy <= !last;
      cnt  <= cnt + CW'(1);
      part <= product;
      mc   <= mc << 1;
      mp   <= mp >> 1;
    end
  end
endmodule

// File: rtl/calc_acc_bank.sv
// calc_acc_bank: NUM_ACC accumulators with a single-cycle ALU, flags and a sequential multiply
module calc_acc_bank
  import calc_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int NUM_ACC = 4
) (
  input logic clk,
  input logic rst,
  calc_acc_bank_if.slave bus
);
  localparam int SELW = $clog2(NUM_ACC);
  localparam int SHW = $clog2(WIDTH);
  localparam logic [WIDTH-1:0] MSB_ONLY = {1'b1, {(WIDTH-1){1'b0}}};
  state_e state, state_nxt;
  op_e op;
  logic [WIDTH-1:0] acc [NUM_ACC];
  logic [WIDTH-1:0] a, d, r, rev;
  logic [SHW-1:0] sh;
  logic [2*WIDTH-1:0] shl_x, shr_x, sra_x, product;
  logic [SELW-1:0] msel;
  logic [3:0] f, mf;
  logic c, v, cmp, accept, single, mul_start, mul_last, mul_busy;
  assign op = op_e'(bus.op_code);
  assign accept = bus.op_valid && bus.op_ready;
  assign mul_start = accept && op == OP_MUL;
  assign single = accept && op != OP_MUL;
  assign a = acc[bus.op_sel];
  assign d = bus.op_data;
  assign sh = d[SHW-1:0];
  assign shl_x = {{WIDTH{1'b0}}, a} << sh;
  assign shr_x = {a, {WIDTH{1'b0}}} >> sh;
  assign sra_x = $signed({a, {WIDTH{1'b0}}}) >>> sh;
  assign cmp = op inside {OP_LTU, OP_GTU, OP_EQ};
  assign bus.acc_out = acc[bus.rd_sel];
  assign bus.busy = mul_busy;
  genvar i;
  for (i = 0; i < WIDTH; i++) begin : g_rev
    assign rev[i] = a[WIDTH-1-i];
  end
  calc_mul_seq #(.WIDTH(WIDTH)) u_mul (
    .clk(clk),
    .rst(rst),
    .start(mul_start),
    .a(a),
    .b(d),
    .busy(mul_busy),
    .last(mul_last),
    .product(product)
  );
  // single-cycle ALU result and carry/overflow for the presented command
  always_comb begin
    r = a;
    c = 1'b0;
    v = 1'b0;
    case (op)
      OP_ADD:  begin
        {c, r} = {1'b0, a} + {1'b0, d};
        v = a[WIDTH-1] == d[WIDTH-1] && r[WIDTH-1] != a[WIDTH-1];
      end
      OP_SUB:  begin
        r = a - d;
        c = a < d;
        v = a[WIDTH-1] != d[WIDTH-1] && r[WIDTH-1] != a[WIDTH-1];
      end
      OP_OR:   r = a | d;
      OP_AND:  r = a & d;
      OP_XOR:  r = a ^ d;
      OP_SHL:  {c, r} = shl_x[WIDTH:0];
      OP_SHR:  {r, c} = shr_x[2*WIDTH-1:WIDTH-1];
      OP_SRA:  {r, c} = sra_x[2*WIDTH-1:WIDTH-1];
      OP_NEG:  begin
        r = -a;
        v = a == MSB_ONLY;
      end
      OP_NOT:  r = ~a;
      OP_REV:  r = rev;
      OP_LOAD: r = d;
      OP_LTU:  r = WIDTH'(a < d);
      OP_GTU:  r = WIDTH'(a > d);
      OP_EQ:   r = WIDTH'(a == d);
      default: r = a;
    endcase
    f = '0;
    f[FLG_C] = c;
    f[FLG_V] = v;
    f[FLG_N] = r[WIDTH-1] && !cmp;
    f[FLG_Z] = r == '0;
    mf = '0;
    mf[FLG_C] = |product[2*WIDTH-1:WIDTH];
    mf[FLG_V] = |product[2*WIDTH-1:WIDTH];
    mf[FLG_N] = product[WIDTH-1];
    mf[FLG_Z] = product[WIDTH-1:0] == '0;
  end
  // control state register
  always_ff @(posedge clk) state <= rst ? IDLE : state_nxt;
  // next state and command acceptance
  always_comb begin
    state_nxt = state;
    bus.op_ready = state == IDLE;
    if (state == IDLE && mul_start) state_nxt = MUL;
    if (state == MUL && mul_last) state_nxt = IDLE;
  end
  // accumulator writes, flags and the completion pulse
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < NUM_ACC; k++) acc[k] <= '0;
      bus.flags <= '0;
      bus.done  <= 1'b0;
      msel      <= '0;
    end else begin
      bus.done <= single || mul_last;
      if (single) begin
        acc[bus.op_sel] <= r;
        bus.flags <= f;
      end
      if (mul_start) msel <= bus.op_sel;
      if (mul_last) begin
        acc[msel] <= product[WIDTH-1:0];
        bus.flags <= mf;
      end
    end
  end
endmodule

// File: tb/tb_calc_acc_bank.sv
// tb_calc_acc_bank: scoreboard bench for the accumulator bank against an independent reference model
module tb_calc_acc_bank;
  typedef struct {
    logic [1:0] sel;
    logic [7:0] val;
    logic [3:0] flg;
  } exp_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int n_cmp = 0;
  int n_bad = 0;
  int n_done = 0;
  int n_push = 0;
  exp_t q[$];
  logic [7:0] mdl [4];
  calc_acc_bank_if #(.WIDTH(8), .NUM_ACC(4)) bus ();
  calc_acc_bank #(.WIDTH(8), .NUM_ACC(4)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  function automatic void model(input logic [3:0] op, input logic [7:0] a, input logic [7:0] d,
                                output logic [7:0] r, output logic [3:0] f);
    int s, sa, sd;
    logic c, v;
    c = 1'b0;
    v = 1'b0;
    r = a;
    sa = int'($signed(a));
    sd = int'($signed(d));
    case (op)
      4'h0: begin s = int'(a) + int'(d); r = s[7:0]; c = s > 255; v = (sa + sd > 127) || (sa + sd < -128); end
      4'h1: begin s = int'(a) - int'(d); r = s[7:0]; c = a < d; v = (sa - sd > 127) || (sa - sd < -128); end
      4'h2: r = a | d;
      4'h3: r = a & d;
      4'h4: r = a ^ d;
      4'h5: for (int k = 0; k < int'(d[2:0]); k++) begin c = r[7]; r = {r[6:0], 1'b0}; end
      4'h6: for (int k = 0; k < int'(d[2:0]); k++) begin c = r[0]; r = {1'b0, r[7:1]}; end
      4'h7: for (int k = 0; k < int'(d[2:0]); k++) begin c = r[0]; r = {r[7], r[7:1]}; end
      4'h8: begin r = 8'(0 - int'(a)); v = a == 8'h80; end
      4'h9: r = ~a;
      4'hA: for (int k = 0; k < 8; k++) r[k] = a[7-k];
      4'hB: begin s = int'(a) * int'(d); r = s[7:0]; c = s > 255; v = s > 255; end
      4'hC: r = d;
      4'hD: r = (a < d) ? 8'd1 : 8'd0;
      4'hE: r = (a > d) ? 8'd1 : 8'd0;
      default: r = (a == d) ? 8'd1 : 8'd0;
    endcase
    f = {c, v, (op >= 4'hD) ? 1'b0 : r[7], r == 8'd0};
  endfunction
  task automatic send(input logic [3:0] op, input logic [1:0] sel, input logic [7:0] data);
    exp_t e;
    int w;
    e.sel = sel;
    model(op, mdl[sel], data, e.val, e.flg);
    mdl[sel] = e.val;
    q.push_back(e);
    n_push++;
    bus.op_valid = 1'b1;
    bus.op_code = op;
    bus.op_sel = sel;
    bus.op_data = data;
    bus.rd_sel = sel;
    w = 0;
    while (!bus.op_ready && w < 50) begin
      @(posedge clk);
      #1;
      w++;
    end
    if (w == 50) chk("ready_timeout", 0, 1);
    @(posedge clk);
    #1;
    bus.op_valid = 1'b0;
  endtask
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask
  // scoreboard: every done pulse retires the oldest expected result
  always @(negedge clk) begin
    if (!rst && bus.done) begin
      exp_t e;
      n_done++;
      if (q.size() == 0) chk("done_unexpected", 1, 0);
      else begin
        e = q.pop_front();
        chk("flags", bus.flags, e.flg);
        if (bus.rd_sel == e.sel) chk("acc", bus.acc_out, e.val);
      end
    end
  end
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    int w;
    logic [7:0] keep0;
    for (int k = 0; k < 4; k++) mdl[k] = 8'd0;
    bus.op_valid = 1'b0;
    bus.op_code = 4'h0;
    bus.op_sel = 2'd0;
    bus.op_data = 8'd0;
    bus.rd_sel = 2'd0;
    tick(2);
    rst = 1'b0;
    chk("rst_ready", bus.op_ready, 1);
    chk("rst_busy", bus.busy, 0);
    chk("rst_done", bus.done, 0);
    chk("rst_flags", bus.flags, 0);
    chk("rst_acc", bus.acc_out, 0);
    send(4'hC, 2'd0, 8'h7F);
    send(4'h0, 2'd0, 8'h01);
    chk("add_done_lat", bus.done, 1);
    chk("add_ovf_acc", bus.acc_out, 8'h80);
    chk("add_ovf_flags", bus.flags, 4'b0110);
    tick(1);
    chk("done_one_cycle", bus.done, 0);
    send(4'hC, 2'd3, 8'h00);
    send(4'h1, 2'd3, 8'h01);
    chk("sub_borrow_flags", bus.flags, 4'b1010);
    send(4'h0, 2'd3, 8'h01);
    chk("wrap_flags", bus.flags, 4'b1001);
    send(4'hC, 2'd2, 8'h10);
    send(4'hB, 2'd2, 8'h11);
    bus.rd_sel = 2'd0;
    w = 0;
    while (!bus.op_ready && w < 40) begin
      chk("mul_busy", bus.busy, 1);
      chk("mul_acc0_read", bus.acc_out, 8'h80);
      tick(1);
      w++;
    end
    bus.rd_sel = 2'd2;
    chk("mul_ready_low_cycles", w, 8);
    chk("mul_done", bus.done, 1);
    chk("mul_acc", bus.acc_out, 8'h10);
    chk("mul_flags", bus.flags, 4'b1100);
    tick(1);
    chk("mul_done_once", bus.done, 0);
    keep0 = mdl[0];
    send(4'hC, 2'd1, 8'h90);
    send(4'h7, 2'd1, 8'h02);
    chk("sra_acc", bus.acc_out, 8'hE4);
    chk("sra_flags", bus.flags, 4'b0010);
    send(4'h6, 2'd1, 8'h01);
    chk("shr_acc", bus.acc_out, 8'h72);
    chk("shr_flags", bus.flags, 4'b0000);
    bus.rd_sel = 2'd0;
    #1 chk("iso_acc0", bus.acc_out, keep0);
    bus.rd_sel = 2'd3;
    #1 chk("iso_acc3", bus.acc_out, 8'h00);
    send(4'hA, 2'd1, 8'h00);
    send(4'h8, 2'd1, 8'h00);
    send(4'h2, 2'd1, 8'h0F);
    send(4'h5, 2'd1, 8'h03);
    send(4'hD, 2'd1, 8'hFF);
    send(4'hE, 2'd2, 8'h01);
    send(4'hF, 2'd3, 8'h00);
    send(4'hC, 2'd0, 8'h80);
    send(4'h8, 2'd0, 8'h00);
    send(4'h9, 2'd0, 8'h00);
    send(4'h4, 2'd0, 8'hAA);
    send(4'h3, 2'd0, 8'h3C);
    tick(2);
    send(4'hC, 2'd0, 8'h00);
    for (int k = 0; k < 4; k++) send(4'h0, 2'd0, 8'h01);
    tick(1);
    chk("b2b_acc", bus.acc_out, 8'd4);
    send(4'hC, 2'd1, 8'h05);
    send(4'hB, 2'd1, 8'h03);
    send(4'h0, 2'd1, 8'h01);
    chk("stall_acc", bus.acc_out, 8'h10);
    tick(2);
    chk("sb_drained", q.size(), 0);
    send(4'hB, 2'd1, 8'h07);
    tick(2);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    void'(q.pop_back());
    n_push--;
    for (int k = 0; k < 4; k++) mdl[k] = 8'd0;
    chk("abort_ready", bus.op_ready, 1);
    chk("abort_busy", bus.busy, 0);
    chk("abort_flags", bus.flags, 0);
    chk("abort_done", bus.done, 0);
    for (int k = 0; k < 4; k++) begin
      bus.rd_sel = 2'(k);
      #1 chk("abort_acc", bus.acc_out, 0);
    end
    tick(10);
    chk("abort_no_done", n_done, n_push);
    chk("sb_empty", q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
